// File: rtl/memory_types_pkg.sv
// Shared memory packet format, operation encodings and requester identities
// used by the core-side and memory-side ports of the arbiter.
package memory_types_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   typedef enum logic {
      MEM_READ  = 1'b0,
      MEM_WRITE = 1'b1
   } mem_op_t;

   typedef struct packed {
      mem_op_t           op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [BE_W-1:0]   be;
   } mem_pkt_t;

   // The encoding doubles as the owner tag stored per outstanding request
   typedef enum logic {
      REQ_IMEM = 1'b0,
      REQ_DMEM = 1'b1
   } req_id_t;

   function automatic req_id_t other_req(input req_id_t id);
      return (id == REQ_IMEM) ? REQ_DMEM : REQ_IMEM;
   endfunction

endpackage

// File: rtl/owner_fifo.sv
// Small FIFO of 1-bit owner tags, one entry per request still waiting for its
// response. DEPTH must be a power of two so the pointers wrap naturally.
module owner_fifo #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic push_tag,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0] tags;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head    = tags[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         tags   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            tags[wr_ptr] <= push_tag;
            wr_ptr       <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         // A push and a pop in the same cycle cancel out in the occupancy
         if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging instruction and data request streams onto one
// in-order memory port, steering each response back to the side that issued it.
module mem_arbiter
   import memory_types_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic     clk,
   input  logic     rst,

   input  logic     imem_req_vld,
   output logic     imem_req_rdy,
   input  mem_pkt_t imem_req,
   output logic     imem_rsp_vld,
   input  logic     imem_rsp_rdy,
   output mem_pkt_t imem_rsp,

   input  logic     dmem_req_vld,
   output logic     dmem_req_rdy,
   input  mem_pkt_t dmem_req,
   output logic     dmem_rsp_vld,
   input  logic     dmem_rsp_rdy,
   output mem_pkt_t dmem_rsp,

   output logic     mem_req_vld,
   input  logic     mem_req_rdy,
   output mem_pkt_t mem_req,
   input  logic     mem_rsp_vld,
   output logic     mem_rsp_rdy,
   input  mem_pkt_t mem_rsp,

   output logic     err_orphan_rsp
);

   req_id_t last_grant;
   req_id_t winner;
   logic    winner_vld;
   logic    req_open;
   logic    req_accept;

   logic    owner_full;
   logic    owner_empty;
   logic    owner_head;
   logic    head_valid;
   logic    rsp_pop;
   logic    orphan;

   // On a conflict the side that did not get the previous grant goes first
   always_comb begin
      winner = other_req(last_grant);
      if (imem_req_vld && !dmem_req_vld) begin
         winner = REQ_IMEM;
      end else if (dmem_req_vld && !imem_req_vld) begin
         winner = REQ_DMEM;
      end
   end

   always_comb begin
      winner_vld   = (winner == REQ_IMEM) ? imem_req_vld : dmem_req_vld;
      mem_req      = (winner == REQ_IMEM) ? imem_req : dmem_req;
      mem_req_vld  = winner_vld && !owner_full && !rst;
      req_open     = mem_req_rdy && !owner_full && !rst;
      imem_req_rdy = (winner == REQ_IMEM) && req_open;
      dmem_req_rdy = (winner == REQ_DMEM) && req_open;
      req_accept   = mem_req_vld && mem_req_rdy;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= REQ_IMEM;
      end else if (req_accept) begin
         last_grant <= winner;
      end
   end

   owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (req_accept),
      .push_tag (winner),
      .pop      (rsp_pop),
      .full     (owner_full),
      .empty    (owner_empty),
      .head     (owner_head)
   );

   // A response with no tag waiting is swallowed so memory never stalls on it
   always_comb begin
      head_valid   = !owner_empty && !rst;
      imem_rsp     = mem_rsp;
      dmem_rsp     = mem_rsp;
      imem_rsp_vld = 1'b0;
      dmem_rsp_vld = 1'b0;
      mem_rsp_rdy  = 1'b1;
      if (head_valid) begin
         if (req_id_t'(owner_head) == REQ_IMEM) begin
            imem_rsp_vld = mem_rsp_vld;
            mem_rsp_rdy  = imem_rsp_rdy;
         end else begin
            dmem_rsp_vld = mem_rsp_vld;
            mem_rsp_rdy  = dmem_rsp_rdy;
         end
      end
      rsp_pop = mem_rsp_vld && mem_rsp_rdy && head_valid;
      orphan  = mem_rsp_vld && !head_valid && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_orphan_rsp <= 1'b0;
      end else if (orphan) begin
         err_orphan_rsp <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario-driven bench for mem_arbiter: accepted requests are queued by the
// bench, a behavioural memory answers them in order, and routed responses are scored.
module tb_mem_arbiter;
   import memory_types_pkg::*;

   typedef struct packed {
      req_id_t  owner;
      mem_pkt_t pkt;
   } pend_t;

   logic     clk = 1'b0;
   logic     rst;
   logic     imem_req_vld, imem_req_rdy, imem_rsp_vld, imem_rsp_rdy;
   logic     dmem_req_vld, dmem_req_rdy, dmem_rsp_vld, dmem_rsp_rdy;
   logic     mem_req_vld, mem_req_rdy, mem_rsp_vld, mem_rsp_rdy;
   logic     err_orphan_rsp;
   mem_pkt_t imem_req, imem_rsp, dmem_req, dmem_rsp, mem_req, mem_rsp;

   int errors = 0;
   int checks = 0;

   pend_t    pend_q[$];
   mem_pkt_t exp_imem_q[$];
   mem_pkt_t exp_dmem_q[$];

   always #5 clk = ~clk;

   mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_vld   (imem_req_vld),
      .imem_req_rdy   (imem_req_rdy),
      .imem_req       (imem_req),
      .imem_rsp_vld   (imem_rsp_vld),
      .imem_rsp_rdy   (imem_rsp_rdy),
      .imem_rsp       (imem_rsp),
      .dmem_req_vld   (dmem_req_vld),
      .dmem_req_rdy   (dmem_req_rdy),
      .dmem_req       (dmem_req),
      .dmem_rsp_vld   (dmem_rsp_vld),
      .dmem_rsp_rdy   (dmem_rsp_rdy),
      .dmem_rsp       (dmem_rsp),
      .mem_req_vld    (mem_req_vld),
      .mem_req_rdy    (mem_req_rdy),
      .mem_req        (mem_req),
      .mem_rsp_vld    (mem_rsp_vld),
      .mem_rsp_rdy    (mem_rsp_rdy),
      .mem_rsp        (mem_rsp),
      .err_orphan_rsp (err_orphan_rsp)
   );

   function automatic mem_pkt_t mk_pkt(input mem_op_t op, input logic [31:0] addr,
                                       input logic [31:0] data);
      mem_pkt_t p;
      p.op   = op;
      p.addr = addr;
      p.data = data;
      p.be   = 4'hF;
      return p;
   endfunction

   function automatic pend_t mk_pend(input req_id_t owner, input mem_pkt_t pkt);
      pend_t p;
      p.owner = owner;
      p.pkt   = pkt;
      return p;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      imem_req_vld = 1'b0;
      dmem_req_vld = 1'b0;
      mem_req_rdy  = 1'b1;
      mem_rsp_vld  = 1'b0;
      imem_rsp_rdy = 1'b1;
      dmem_rsp_rdy = 1'b1;
      imem_req     = '0;
      dmem_req     = '0;
      mem_rsp      = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      next_cycle();
      next_cycle();
      rst = 1'b0;
      pend_q.delete();
      exp_imem_q.delete();
      exp_dmem_q.delete();
   endtask

   // Behavioural memory: answer the oldest accepted request, recording where it must go
   task automatic issue_rsp(output req_id_t side);
      pend_t    p;
      mem_pkt_t r;
      p      = pend_q.pop_front();
      r      = p.pkt;
      r.data = p.pkt.data ^ p.pkt.addr ^ 32'h5A5A_0000;
      mem_rsp_vld = 1'b1;
      mem_rsp     = r;
      side        = p.owner;
      if (p.owner == REQ_IMEM) exp_imem_q.push_back(r);
      else                     exp_dmem_q.push_back(r);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      imem_req_vld = 1'b1;
      imem_req     = mk_pkt(MEM_READ, 32'h100, 32'h0);
      mem_rsp_vld  = 1'b1;
      next_cycle();
      next_cycle();
      checks++;
      if (mem_req_vld !== 1'b0 || imem_req_rdy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_req got vld=%b rdy=%b required 0/0", mem_req_vld, imem_req_rdy);
      end
      checks++;
      if (imem_rsp_vld !== 1'b0 || dmem_rsp_vld !== 1'b0 || err_orphan_rsp !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_rsp got ivld=%b dvld=%b err=%b required 0/0/0",
                  imem_rsp_vld, dmem_rsp_vld, err_orphan_rsp);
      end
      rst = 1'b0;
      idle_inputs();
      next_cycle();
      checks++;
      if (mem_req_vld !== 1'b0 || mem_rsp_rdy !== 1'b1 || err_orphan_rsp !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_exit got mvld=%b mrdy=%b err=%b required 0/1/0",
                  mem_req_vld, mem_rsp_rdy, err_orphan_rsp);
      end
   endtask

   task automatic test_round_robin();
      req_id_t  side, exp_owner;
      mem_pkt_t exp_pkt, exp_rsp;
      do_reset();
      imem_req = mk_pkt(MEM_READ, 32'h100, 32'h0);
      dmem_req = mk_pkt(MEM_READ, 32'h2000, 32'h0);
      for (int k = 0; k < 5; k++) begin
         imem_req_vld = (k < 4);
         dmem_req_vld = (k < 4);
         side         = REQ_IMEM;
         if (k > 0) issue_rsp(side);
         else       mem_rsp_vld = 1'b0;
         exp_owner = (k % 2 == 0) ? REQ_DMEM : REQ_IMEM;
         exp_pkt   = (exp_owner == REQ_DMEM) ? dmem_req : imem_req;
         if (k < 4) pend_q.push_back(mk_pend(exp_owner, exp_pkt));
         #1;
         if (k < 4) begin
            checks++;
            if (mem_req_vld !== 1'b1 || mem_req !== exp_pkt ||
                imem_req_rdy !== (exp_owner == REQ_IMEM) || dmem_req_rdy !== (exp_owner == REQ_DMEM)) begin
               errors++;
               $display("[TB] FAIL rr_grant k=%0d got addr=%h vld=%b irdy=%b drdy=%b required addr=%h",
                        k, mem_req.addr, mem_req_vld, imem_req_rdy, dmem_req_rdy, exp_pkt.addr);
            end
         end
         if (k > 0) begin
            checks++;
            exp_rsp = (side == REQ_IMEM) ? exp_imem_q.pop_front() : exp_dmem_q.pop_front();
            if (imem_rsp_vld !== (side == REQ_IMEM) || dmem_rsp_vld !== (side == REQ_DMEM) ||
                ((side == REQ_IMEM) ? imem_rsp : dmem_rsp) !== exp_rsp || mem_rsp_rdy !== 1'b1) begin
               errors++;
               $display("[TB] FAIL rr_rsp k=%0d got ivld=%b dvld=%b data=%h required side=%0d data=%h",
                        k, imem_rsp_vld, dmem_rsp_vld, mem_rsp.data, side, exp_rsp.data);
            end
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_grant_hold();
      req_id_t  side;
      mem_pkt_t exp_rsp;
      do_reset();
      imem_req     = mk_pkt(MEM_READ, 32'h100, 32'h0);
      dmem_req     = mk_pkt(MEM_READ, 32'h2000, 32'h0);
      imem_req_vld = 1'b1;
      dmem_req_vld = 1'b1;
      mem_req_rdy  = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (mem_req_vld !== 1'b1 || mem_req !== dmem_req || imem_req_rdy !== 1'b0 || dmem_req_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_stall k=%0d got addr=%h vld=%b irdy=%b drdy=%b required addr=%h vld=1 rdy=0/0",
                     k, mem_req.addr, mem_req_vld, imem_req_rdy, dmem_req_rdy, dmem_req.addr);
         end
         next_cycle();
      end
      mem_req_rdy = 1'b1;
      for (int k = 0; k < 2; k++) begin
         pend_q.push_back(mk_pend((k == 0) ? REQ_DMEM : REQ_IMEM, (k == 0) ? dmem_req : imem_req));
         #1;
         checks++;
         if (mem_req_vld !== 1'b1 || mem_req !== ((k == 0) ? dmem_req : imem_req)) begin
            errors++;
            $display("[TB] FAIL hold_grant k=%0d got addr=%h vld=%b required addr=%h",
                     k, mem_req.addr, mem_req_vld, (k == 0) ? dmem_req.addr : imem_req.addr);
         end
         next_cycle();
      end
      imem_req_vld = 1'b0;
      dmem_req_vld = 1'b0;
      for (int k = 0; k < 2; k++) begin
         issue_rsp(side);
         #1;
         checks++;
         exp_rsp = (side == REQ_IMEM) ? exp_imem_q.pop_front() : exp_dmem_q.pop_front();
         if (imem_rsp_vld !== (side == REQ_IMEM) || dmem_rsp_vld !== (side == REQ_DMEM) ||
             ((side == REQ_IMEM) ? imem_rsp : dmem_rsp) !== exp_rsp) begin
            errors++;
            $display("[TB] FAIL hold_rsp k=%0d got ivld=%b dvld=%b required side=%0d data=%h",
                     k, imem_rsp_vld, dmem_rsp_vld, side, exp_rsp.data);
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      req_id_t  side;
      mem_pkt_t exp_rsp;
      do_reset();
      imem_req_vld = 1'b1;
      for (int k = 0; k < 2; k++) begin
         imem_req = mk_pkt(MEM_READ, 32'h100 + 32'(4 * k), 32'h0);
         pend_q.push_back(mk_pend(REQ_IMEM, imem_req));
         #1;
         checks++;
         if (imem_req_rdy !== 1'b1 || mem_req_vld !== 1'b1 || mem_req !== imem_req) begin
            errors++;
            $display("[TB] FAIL bp_fill k=%0d got rdy=%b vld=%b addr=%h required 1/1 addr=%h",
                     k, imem_req_rdy, mem_req_vld, mem_req.addr, imem_req.addr);
         end
         next_cycle();
      end
      imem_req = mk_pkt(MEM_READ, 32'h108, 32'h0);
      for (int k = 0; k < 3; k++) begin
         side = REQ_DMEM;
         if (k == 2) issue_rsp(side);
         #1;
         checks++;
         if (imem_req_rdy !== 1'b0 || mem_req_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_full k=%0d got rdy=%b vld=%b required 0/0", k, imem_req_rdy, mem_req_vld);
         end
         if (k == 2) begin
            checks++;
            exp_rsp = exp_imem_q.pop_front();
            if (side !== REQ_IMEM || imem_rsp_vld !== 1'b1 || dmem_rsp_vld !== 1'b0 || imem_rsp !== exp_rsp) begin
               errors++;
               $display("[TB] FAIL bp_pop_rsp got ivld=%b dvld=%b data=%h required 1/0 data=%h",
                        imem_rsp_vld, dmem_rsp_vld, imem_rsp.data, exp_rsp.data);
            end
         end
         next_cycle();
      end
      mem_rsp_vld = 1'b0;
      pend_q.push_back(mk_pend(REQ_IMEM, imem_req));
      #1;
      checks++;
      if (imem_req_rdy !== 1'b1 || mem_req_vld !== 1'b1 || mem_req !== imem_req) begin
         errors++;
         $display("[TB] FAIL bp_resume got rdy=%b vld=%b addr=%h required 1/1 addr=%h",
                  imem_req_rdy, mem_req_vld, mem_req.addr, imem_req.addr);
      end
      next_cycle();
      imem_req_vld = 1'b0;
      for (int k = 0; k < 2; k++) begin
         issue_rsp(side);
         #1;
         checks++;
         exp_rsp = exp_imem_q.pop_front();
         if (imem_rsp_vld !== 1'b1 || dmem_rsp_vld !== 1'b0 || imem_rsp !== exp_rsp) begin
            errors++;
            $display("[TB] FAIL bp_drain k=%0d got ivld=%b dvld=%b data=%h required 1/0 data=%h",
                     k, imem_rsp_vld, dmem_rsp_vld, imem_rsp.data, exp_rsp.data);
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_routing();
      req_id_t  side;
      mem_pkt_t exp_rsp;
      do_reset();
      imem_req_vld = 1'b1;
      imem_req     = mk_pkt(MEM_READ, 32'h100, 32'h0);
      pend_q.push_back(mk_pend(REQ_IMEM, imem_req));
      #1;
      checks++;
      if (mem_req_vld !== 1'b1 || mem_req !== imem_req) begin
         errors++;
         $display("[TB] FAIL route_req_i got vld=%b addr=%h required 1 addr=%h", mem_req_vld, mem_req.addr, imem_req.addr);
      end
      next_cycle();
      imem_req_vld = 1'b0;
      dmem_req_vld = 1'b1;
      dmem_req     = mk_pkt(MEM_WRITE, 32'h2004, 32'hCAFE_F00D);
      pend_q.push_back(mk_pend(REQ_DMEM, dmem_req));
      #1;
      checks++;
      if (mem_req_vld !== 1'b1 || mem_req !== dmem_req) begin
         errors++;
         $display("[TB] FAIL route_req_d got vld=%b pkt=%h required 1 pkt=%h", mem_req_vld, mem_req, dmem_req);
      end
      next_cycle();
      dmem_req_vld = 1'b0;
      for (int k = 0; k < 2; k++) begin
         issue_rsp(side);
         #1;
         checks++;
         exp_rsp = (side == REQ_IMEM) ? exp_imem_q.pop_front() : exp_dmem_q.pop_front();
         if (side !== ((k == 0) ? REQ_IMEM : REQ_DMEM) ||
             imem_rsp_vld !== (side == REQ_IMEM) || dmem_rsp_vld !== (side == REQ_DMEM) ||
             ((side == REQ_IMEM) ? imem_rsp : dmem_rsp) !== exp_rsp) begin
            errors++;
            $display("[TB] FAIL route_rsp k=%0d got ivld=%b dvld=%b data=%h required side=%0d data=%h",
                     k, imem_rsp_vld, dmem_rsp_vld, mem_rsp.data, side, exp_rsp.data);
         end
         next_cycle();
      end
      idle_inputs();
      #1;
      checks++;
      if (imem_rsp_vld !== 1'b0 || dmem_rsp_vld !== 1'b0 || mem_rsp_rdy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL route_empty got ivld=%b dvld=%b mrdy=%b required 0/0/1",
                  imem_rsp_vld, dmem_rsp_vld, mem_rsp_rdy);
      end
      next_cycle();
   endtask

   task automatic test_rsp_stall();
      req_id_t  side;
      mem_pkt_t exp_rsp;
      do_reset();
      dmem_req_vld = 1'b1;
      dmem_req     = mk_pkt(MEM_READ, 32'h2008, 32'h0);
      pend_q.push_back(mk_pend(REQ_DMEM, dmem_req));
      next_cycle();
      dmem_req_vld = 1'b0;
      issue_rsp(side);
      dmem_rsp_rdy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (mem_rsp_rdy !== 1'b0 || dmem_rsp_vld !== 1'b1 || imem_rsp_vld !== 1'b0 || dmem_rsp !== exp_dmem_q[0]) begin
            errors++;
            $display("[TB] FAIL stall_hold k=%0d got mrdy=%b dvld=%b ivld=%b required 0/1/0",
                     k, mem_rsp_rdy, dmem_rsp_vld, imem_rsp_vld);
         end
         next_cycle();
      end
      dmem_rsp_rdy = 1'b1;
      #1;
      checks++;
      exp_rsp = exp_dmem_q.pop_front();
      if (mem_rsp_rdy !== 1'b1 || dmem_rsp_vld !== 1'b1 || dmem_rsp !== exp_rsp) begin
         errors++;
         $display("[TB] FAIL stall_release got mrdy=%b dvld=%b data=%h required 1/1 data=%h",
                  mem_rsp_rdy, dmem_rsp_vld, dmem_rsp.data, exp_rsp.data);
      end
      next_cycle();
      mem_rsp = mk_pkt(MEM_READ, 32'h0, 32'h0);
      #1;
      checks++;
      if (dmem_rsp_vld !== 1'b0 || imem_rsp_vld !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_single_pop got dvld=%b ivld=%b required 0/0", dmem_rsp_vld, imem_rsp_vld);
      end
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_orphan();
      do_reset();
      mem_rsp_vld = 1'b1;
      mem_rsp     = mk_pkt(MEM_READ, 32'hDEAD0, 32'h1234);
      #1;
      checks++;
      if (mem_rsp_rdy !== 1'b1 || imem_rsp_vld !== 1'b0 || dmem_rsp_vld !== 1'b0 || err_orphan_rsp !== 1'b0) begin
         errors++;
         $display("[TB] FAIL orphan_consume got mrdy=%b ivld=%b dvld=%b err=%b required 1/0/0/0",
                  mem_rsp_rdy, imem_rsp_vld, dmem_rsp_vld, err_orphan_rsp);
      end
      next_cycle();
      mem_rsp_vld = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (err_orphan_rsp !== 1'b1) begin
            errors++;
            $display("[TB] FAIL orphan_sticky k=%0d got err=%b required 1", k, err_orphan_rsp);
         end
         next_cycle();
      end
      rst = 1'b1;
      next_cycle();
      checks++;
      if (err_orphan_rsp !== 1'b0) begin
         errors++;
         $display("[TB] FAIL orphan_clear got err=%b required 0", err_orphan_rsp);
      end
      rst = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      imem_req_vld = 1'b1;
      imem_req     = mk_pkt(MEM_READ, 32'h100, 32'h0);
      #1;
      checks++;
      if (mem_req_vld !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_accept got vld=%b required 1", mem_req_vld);
      end
      next_cycle();
      imem_req_vld = 1'b0;
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      mem_rsp_vld = 1'b1;
      mem_rsp     = mk_pkt(MEM_READ, 32'h100, 32'h77);
      #1;
      checks++;
      if (imem_rsp_vld !== 1'b0 || dmem_rsp_vld !== 1'b0 || mem_rsp_rdy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_rsp got ivld=%b dvld=%b mrdy=%b required 0/0/1",
                  imem_rsp_vld, dmem_rsp_vld, mem_rsp_rdy);
      end
      next_cycle();
      mem_rsp_vld = 1'b0;
      checks++;
      if (err_orphan_rsp !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_orphan got err=%b required 1", err_orphan_rsp);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_grant_hold();
      test_backpressure();
      test_routing();
      test_rsp_stall();
      test_orphan();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
